// File: rtl/enc_pkg.sv
// Shared RV32I encoding definitions: format classes, opcodes and the word encoder.
// Also holds the range rule used when ENC_RANGE_CHECK_EN is defined.
package enc_pkg;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_LUI     = 3'd5,
        CLS_AUIPC   = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instrClass_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } encFields_t;

    function automatic logic [31:0] encode(input instrClass_e cls, input encFields_t f);
        logic [31:0] word;
        word = '0;
        case (cls)
            CLS_R:      word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, OPC_OP};
            CLS_I:      word = {f.imm[11:0], f.rs1, f.funct3, f.rd, OPC_OP_IMM};
            CLS_LOAD:   word = {f.imm[11:0], f.rs1, f.funct3, f.rd, OPC_LOAD};
            CLS_STORE:  word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], OPC_STORE};
            CLS_BRANCH: word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                                f.imm[4:1], f.imm[11], OPC_BRANCH};
            CLS_LUI:    word = {f.imm[31:12], f.rd, OPC_LUI};
            CLS_AUIPC:  word = {f.imm[31:12], f.rd, OPC_AUIPC};
            default:    word = '0;
        endcase
        return word;
    endfunction

    // True when the immediate fits the class's field without truncation.
    function automatic logic inRange(input instrClass_e cls, input logic [31:0] imm);
        case (cls)
            CLS_I, CLS_LOAD, CLS_STORE: return imm == {{20{imm[11]}}, imm[11:0]};
            CLS_BRANCH:                 return (imm == {{19{imm[12]}}, imm[12:0]}) && !imm[0];
            default:                    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO buffering encoded words; flush has priority over push and pop.
// Pointers carry one extra wrap bit so full and empty need no separate counter.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [PTR_W:0]   wrPtr;
    logic [PTR_W:0]   rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign doPush = push && !full && !flush;
    assign doPop  = pop && !empty && !flush;
    assign rdData = mem[rdPtr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[PTR_W-1:0]] <= wrData;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with buffered valid/ready output and byte-address tagging.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              err_range
);
    localparam logic [ADDR_W-1:0] ADDR_RESET = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);

    instrClass_e reqClass;
    encFields_t  reqFields;
    logic [31:0] reqWord;
    logic [31:0] headWord;
    logic        accept;
    logic        isIllegal;
    logic        rangeBad;
    logic        doPush;
    logic        doPop;
    logic        fifoFull;
    logic        fifoEmpty;

    assign reqClass  = instrClass_e'(in_class);
    assign reqFields = '{rd: in_rd, rs1: in_rs1, rs2: in_rs2, funct3: in_funct3,
                         funct7: in_funct7, imm: in_imm};
    assign reqWord   = encode(reqClass, reqFields);

    assign in_ready  = !fifoFull;
    assign accept    = in_valid && in_ready;
    assign isIllegal = (reqClass == CLS_ILLEGAL);
    assign doPush    = accept && !isIllegal && !rangeBad && !flush;

    assign out_valid = !fifoEmpty;
    assign doPop     = out_valid && out_ready;
    // Gate the raw storage so the output reads zero whenever nothing is buffered.
    assign out_instr = fifoEmpty ? '0 : headWord;

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .push   (doPush),
        .pop    (doPop),
        .wrData (reqWord),
        .rdData (headWord),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= ADDR_RESET;
        end else if (flush) begin
            out_addr <= ADDR_RESET;
        end else if (doPop) begin
            out_addr <= out_addr + ADDR_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_illegal <= 1'b0;
        else        err_illegal <= accept && isIllegal && !flush;
    end

`ifdef ENC_RANGE_CHECK_EN
    assign rangeBad = !isIllegal && !inRange(reqClass, in_imm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_range <= 1'b0;
        else        err_range <= accept && rangeBad && !flush;
    end
`else
    assign rangeBad  = 1'b0;
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized bursts
// against an arithmetic reference encoder and an expected-word queue.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        err_illegal;
    logic        err_range;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] expQ[$];
    int unsigned modelAddr;

    logic [2:0]  rCls;
    logic [4:0]  rRd, rRs1, rRs2;
    logic [2:0]  rF3;
    logic [6:0]  rF7;
    logic [31:0] rImm;

    instr_encoder #(
        .FIFO_DEPTH (4),
        .ADDR_W     (10),
        .BASE_ADDR  (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_class    (in_class),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from field weights rather than bit concatenation.
    function automatic logic [31:0] refEncode(input logic [2:0] cls, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] imm);
        int unsigned base, i12, b;
        base = int'(rs1) * 32768 + int'(f3) * 4096;
        i12  = imm % 4096;
        b    = imm % 8192;
        case (cls)
            3'd0: return f7 * 33554432 + rs2 * 1048576 + base + rd * 128 + 'h33;
            3'd1: return i12 * 1048576 + base + rd * 128 + 'h13;
            3'd2: return i12 * 1048576 + base + rd * 128 + 'h03;
            3'd3: return (i12 / 32) * 33554432 + rs2 * 1048576 + base + (i12 % 32) * 128 + 'h23;
            3'd4: return (b / 4096) * 32'h8000_0000 + ((b / 32) % 64) * 33554432
                         + rs2 * 1048576 + base + ((b / 2) % 16) * 256
                         + ((b / 2048) % 2) * 128 + 'h63;
            3'd5: return (imm / 4096) * 4096 + rd * 128 + 'h37;
            3'd6: return (imm / 4096) * 4096 + rd * 128 + 'h17;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit refRangeOk(input logic [2:0] cls, input logic [31:0] imm);
        int s;
        s = int'(imm);
        case (cls)
            3'd1, 3'd2, 3'd3: return (s >= -2048) && (s <= 2047);
            3'd4:             return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            default:          return 1'b1;
        endcase
    endfunction

    task automatic drive(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_class  = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic sendReq(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        bit dropRange;
        drive(cls, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check("accept_wait", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        dropRange = !refRangeOk(cls, imm) && (cls != 3'd7);
`else
        dropRange = 1'b0;
`endif
        check("err_illegal_pulse", {31'b0, err_illegal}, {31'b0, cls == 3'd7});
        check("err_range_pulse", {31'b0, err_range}, {31'b0, dropRange});
        if (cls != 3'd7 && !dropRange) expQ.push_back(refEncode(cls, rd, rs1, rs2, f3, f7, imm));
    endtask

    task automatic popCheck(input string tag);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
        check({tag, "_instr"}, out_instr, (expQ.size() > 0) ? expQ[0] : 32'hDEAD_BEEF);
        check({tag, "_addr"}, 32'(out_addr), modelAddr);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (expQ.size() > 0) void'(expQ.pop_front());
        modelAddr = (modelAddr + 4) % 1024;
    endtask

    task automatic pickRandom(input bit allowIllegal);
        rCls = 3'($urandom_range(0, allowIllegal ? 7 : 6));
        rRd  = 5'($urandom);
        rRs1 = 5'($urandom);
        rRs2 = 5'($urandom);
        rF3  = 3'($urandom);
        rF7  = 7'($urandom);
        if ($urandom_range(0, 7) == 0)  rImm = $urandom;
        else if (rCls == 3'd4)          rImm = 32'(($urandom_range(0, 4095) - 2048) * 2);
        else if (rCls inside {3'd1, 3'd2, 3'd3}) rImm = 32'($urandom_range(0, 4095) - 2048);
        else                            rImm = $urandom;
    endtask

    initial begin
        logic [31:0] fifthWord;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        modelAddr = 0;

        // Reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'h0);
        check("rst_err_illegal", {31'b0, err_illegal}, 32'h0);
        check("rst_err_range", {31'b0, err_range}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // I class, one-cycle latency
        sendReq(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        check("i_latency_valid", {31'b0, out_valid}, 32'h1);
        check("i_word", out_instr, 32'h0050_0093);
        check("i_addr", 32'(out_addr), 32'h0);
        popCheck("i");

        // Fill 3, then flush together with a push
        sendReq(3'd1, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd7);
        sendReq(3'd0, 5'd4, 5'd5, 5'd6, 3'd1, 7'd0, 32'd0);
        sendReq(3'd5, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
        drive(3'd1, 5'd9, 5'd9, 5'd0, 3'd0, 7'd0, 32'd9);
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        expQ.delete(); modelAddr = 0;
        check("flush_empty", {31'b0, out_valid}, 32'h0);
        check("flush_addr", 32'(out_addr), 32'h0);
        // Illegal request during flush must not pulse
        drive(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_err_suppressed", {31'b0, err_illegal}, 32'h0);
        check("flush_still_empty", {31'b0, out_valid}, 32'h0);

        // R then STORE after flush
        sendReq(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        check("r_word", out_instr, 32'h0020_81B3);
        popCheck("r");
        sendReq(3'd3, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
        check("st_word", out_instr, 32'h0020_A423);
        check("st_addr", 32'(out_addr), 32'h4);
        popCheck("st");

        // BRANCH with negative offset, then LUI
        sendReq(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
        check("br_word", out_instr, 32'hFE20_8EE3);
        popCheck("br");
        sendReq(3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        check("lui_word", out_instr, 32'h1234_52B7);
        popCheck("lui");

        // Backpressure: four accepts fill the buffer, fifth waits for a pop
        for (int i = 0; i < 4; i++) begin
            pickRandom(1'b0);
            if (rCls inside {3'd1, 3'd2, 3'd3, 3'd4}) rImm = 32'd16;
            sendReq(rCls, rRd, rRs1, rRs2, rF3, rF7, rImm);
        end
        check("bp_full", {31'b0, in_ready}, 32'h0);
        check("bp_head", out_instr, expQ[0]);
        drive(3'd6, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F123);
        fifthWord = refEncode(3'd6, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F123);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_hold_instr", out_instr, expQ[0]);
        check("bp_hold_addr", 32'(out_addr), modelAddr);
        check("bp_no_accept", {31'b0, in_ready}, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        void'(expQ.pop_front());
        modelAddr = (modelAddr + 4) % 1024;
        check("bp_ready_after_pop", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        expQ.push_back(fifthWord);
        for (int i = 0; i < 4; i++) popCheck("bp_drain");
        check("bp_drained", {31'b0, out_valid}, 32'h0);

        // Illegal class and out-of-range immediate
        sendReq(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        check("ill_no_output", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        check("ill_pulse_once", {31'b0, err_illegal}, 32'h0);
        sendReq(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
`ifdef ENC_RANGE_CHECK_EN
        check("range_no_output", {31'b0, out_valid}, 32'h0);
`else
        check("trunc_word", out_instr, 32'h8000_0093);
        popCheck("trunc");
`endif

        // Randomized bursts; enough words to wrap the address counter
        for (int burst = 0; burst < 120; burst++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                pickRandom(1'b1);
                sendReq(rCls, rRd, rRs1, rRs2, rF3, rF7, rImm);
            end
            while (expQ.size() > 0) popCheck("rand");
        end
        check("rand_drained", {31'b0, out_valid}, 32'h0);

        // Asynchronous reset mid-stream
        sendReq(3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1);
        sendReq(3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check("arst_out_instr", out_instr, 32'h0);
        check("arst_out_addr", 32'(out_addr), 32'h0);
        expQ.delete(); modelAddr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        sendReq(3'd6, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
        popCheck("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart of the main control decoder: takes instruction intent (format class plus fields) and emits 32-bit RV32I instruction words.
- Feeds the instruction-memory loader and the test-program generator over a buffered valid/ready stream.
- Each emitted word is tagged with a byte address from an internal word counter.
- Covers exactly the opcode set the control unit decodes: R, I, LOAD, STORE, BRANCH, LUI, AUIPC.

Parameters:
- FIFO_DEPTH, 4, number of encoded words buffered; power of 2, minimum 2.
- ADDR_W, 10, width of out_addr in bits.
- BASE_ADDR, 0, out_addr value after reset or flush; multiple of 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of buffer and address counter.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_class  in  3  format class (package enum).
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R class only).
- in_imm  in  32  immediate; byte offset for BRANCH; upper value with low 12 bits ignored for LUI/AUIPC.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer ready.
- out_instr  out  32  encoded instruction word.
- out_addr  out  ADDR_W  byte address of out_instr.
- err_illegal  out  1  one-cycle pulse when a request is dropped for an illegal class.
- err_range  out  1  one-cycle pulse when a request is dropped for a range violation (optional feature).

Behaviour:
- Reset (async, rst_n=0): FIFO empty; out_valid=0; out_instr=0; out_addr=BASE_ADDR; err_illegal=0; err_range=0. in_ready=1 from the first cycle after release.
- Encoding (combinational on the input, written into the FIFO on accept):
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}.
  - I: {imm[11:0], rs1, funct3, rd, 0010011}.
  - LOAD: {imm[11:0], rs1, funct3, rd, 0000011}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
  - LUI: {imm[31:12], rd, 0110111}.
  - AUIPC: {imm[31:12], rd, 0010111}.
  - Fields not used by a class are ignored.
- Class 3'b111 is illegal: the request is accepted, nothing is pushed, and err_illegal pulses on the cycle after acceptance.
- Latency: a request accepted in cycle N is presented on out_instr/out_valid in cycle N+1 at the earliest; FIFO order is preserved.
- in_ready = !full. There is no pass-through when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full or empty: both take effect; occupancy is unchanged.
- out_addr belongs to the head word. It advances by 4 on each out_valid && out_ready and wraps modulo 2^ADDR_W.
- out_instr/out_addr hold stable while out_valid && !out_ready.
- flush: on the next edge the FIFO empties and out_addr=BASE_ADDR. A push in the same cycle is discarded; flush wins. Error pulses are suppressed that cycle.
- rst_n asserted mid-stream: all state clears immediately; buffered words are lost.

Optional Feature:
- Macro: ENC_RANGE_CHECK_EN.
- Defined:
  - I, LOAD and STORE require in_imm to be the sign-extension of imm[11:0].
  - BRANCH requires in_imm to be the sign-extension of imm[12:0] with imm[0]=0.
  - On violation the request is accepted but dropped, and err_range pulses on the cycle after acceptance.
- Undefined: fields are silently truncated and err_range is tied to 0.

Decomposition:
- Package enc_pkg holds:
  - the class enum (R=0, I=1, LOAD=2, STORE=3, BRANCH=4, LUI=5, AUIPC=6);
  - the seven 7-bit opcode constants, shared with the control decoder;
  - a pure function encode(class, fields) returning the 32-bit word.
- One sub-module: enc_fifo, a synchronous FIFO with depth parameter, push/pop, full/empty and flush. The top level holds input encoding, error pulses and the address counter.

Test Plan:
- I class, rd=1, rs1=0, funct3=0, imm=5 -> out_instr=0x00500093, out_addr=0x000, one cycle after accept.
- R class, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x002081B3. Then STORE, rs1=1, rs2=2, funct3=010, imm=8 -> 0x0020A423 at addr 0x004.
- BRANCH, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3. Then LUI, rd=5, imm=0x12345000 -> 0x123452B7.
- Hold out_ready=0 and push 5 requests -> in_ready low after 4 accepts. Release -> 4 words at addr 0, 4, 8, 12; the 5th is accepted after the first pop.
- Push class 7 -> err_illegal pulses once, no output. With ENC_RANGE_CHECK_EN: I class with imm=0x800 -> err_range pulses, no output; without the macro -> 0x80000093.
- Fill 3 words, then assert flush together with in_valid -> FIFO empty, out_addr=BASE_ADDR, the pushed word is absent. Pulse rst_n low mid-stream -> all outputs at reset values asynchronously.
